// File: rtl/dsp_volume_matrix.sv
// DSP volume matrix: decodes the FMA DSP register write stream into an
// NUM_CH x NUM_CH attenuation matrix. A full set of dB bytes is committed
// atomically as linear gains, and each current gain ramps toward its target
// once per sample tick so that volume changes do not click.
module dsp_volume_matrix #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        dspa,
  input  logic [7:0]                        dspd,
  input  logic                              dspd_strobe,
  input  logic                              sample_tick,
  output logic [NUM_CH*NUM_CH*GAIN_W-1:0]   volume,
  output logic                              volume_valid,
  output logic                              ramping
);

  localparam int unsigned      N2        = NUM_CH * NUM_CH;
  localparam int unsigned      IdxW      = (N2 > 1) ? $clog2(N2) : 1;
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(N2 - 1);
  localparam logic [GAIN_W:0]  Step      = (GAIN_W + 1)'(RAMP_STEP);
  localparam logic [GAIN_W-1:0] UnityGain = GAIN_W'(144);

  localparam logic [7:0] ModeMagic = 8'h80;
  localparam logic [7:0] ArmMagic  = 8'h93;

  // round(144 * 10^(-dB/20)) for dB = 0..49; 50 dB and beyond is silence.
  localparam logic [7:0] DbTable [50] = '{
    8'd144, 8'd128, 8'd114, 8'd102, 8'd91,  8'd81,  8'd72,  8'd64,  8'd57,  8'd51,
    8'd46,  8'd41,  8'd36,  8'd32,  8'd29,  8'd26,  8'd23,  8'd20,  8'd18,  8'd16,
    8'd14,  8'd13,  8'd11,  8'd10,  8'd9,   8'd8,   8'd7,   8'd6,   8'd6,   8'd5,
    8'd5,   8'd4,   8'd4,   8'd3,   8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd2,
    8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1
  };

  // Bit 7 is mute; otherwise bits 6:0 are attenuation in dB.
  function automatic logic [GAIN_W-1:0] db_to_gain(input logic [7:0] b);
    if (b[7] || (b[6:0] >= 7'd50)) begin
      return '0;
    end
    return GAIN_W'(DbTable[b[5:0]]);
  endfunction

  // One ramp step toward the target, evaluated one bit wider so it cannot wrap.
  function automatic logic [GAIN_W-1:0] ramp_one(input logic [GAIN_W-1:0] cur,
                                                 input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W:0] c;
    logic [GAIN_W:0] t;
    logic [GAIN_W:0] up;
    logic [GAIN_W:0] down;
    c    = {1'b0, cur};
    t    = {1'b0, tgt};
    up   = c + Step;
    down = c - Step;
    if (c < t) begin
      return (up > t) ? tgt : up[GAIN_W-1:0];
    end else if (c > t) begin
      return (c >= t + Step) ? down[GAIN_W-1:0] : tgt;
    end
    return cur;
  endfunction

  logic [7:0]        mode_q, mode_d;
  logic [7:0]        dsp_target_q, dsp_target_d;
  logic              armed_q, armed_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic              valid_q, valid_d;
  logic              ramping_q, ramping_d;
  logic [7:0]        shadow_q [N2];
  logic [7:0]        shadow_d [N2];
  logic [GAIN_W-1:0] cur_q [N2];
  logic [GAIN_W-1:0] cur_d [N2];
  logic [GAIN_W-1:0] tgt_q [N2];
  logic [GAIN_W-1:0] tgt_d [N2];

  // Register decode: mode/arm handshake, shadow fill and atomic commit.
  always_comb begin
    mode_d       = mode_q;
    dsp_target_d = dsp_target_q;
    armed_d      = armed_q;
    index_d      = index_q;
    valid_d      = valid_q;
    shadow_d     = shadow_q;
    tgt_d        = tgt_q;
    if (dspd_strobe) begin
      case (dspa)
        8'd0: begin
          // Any mode write aborts a partial sequence.
          mode_d  = dspd;
          armed_d = 1'b0;
          index_d = '0;
        end
        8'd1: begin
          dsp_target_d = dspd;
          if ((mode_q == ModeMagic) && (dspd == ArmMagic)) begin
            armed_d = 1'b1;
            index_d = '0;
          end else begin
            armed_d = 1'b0;
          end
        end
        8'd7: begin
          if (armed_q) begin
            shadow_d[index_q] = dspd;
            if (index_q == LastIdx) begin
              // The final byte bypasses the shadow so all entries land together.
              for (int unsigned k = 0; k < N2; k++) begin
                tgt_d[k] = db_to_gain((k == N2 - 1) ? dspd : shadow_q[k]);
              end
              valid_d = 1'b1;
              index_d = '0;
            end else begin
              index_d = index_q + IdxW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gain ramp: always toward the registered (old) targets, so a commit in the
  // same cycle as a tick only takes effect from the next tick.
  always_comb begin
    ramping_d = 1'b0;
    for (int unsigned k = 0; k < N2; k++) begin
      cur_d[k] = cur_q[k];
      if (RAMP_STEP == 0) begin
        cur_d[k] = tgt_q[k];
      end else if (sample_tick) begin
        cur_d[k] = ramp_one(cur_q[k], tgt_q[k]);
      end
      if (cur_q[k] != tgt_q[k]) begin
        ramping_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q       <= '0;
      dsp_target_q <= '0;
      armed_q      <= 1'b0;
      index_q      <= '0;
      valid_q      <= 1'b0;
      ramping_q    <= 1'b0;
      for (int unsigned k = 0; k < N2; k++) begin
        shadow_q[k] <= '0;
        cur_q[k]    <= ((k % (NUM_CH + 1)) == 0) ? UnityGain : '0;
        tgt_q[k]    <= ((k % (NUM_CH + 1)) == 0) ? UnityGain : '0;
      end
    end else begin
      mode_q       <= mode_d;
      dsp_target_q <= dsp_target_d;
      armed_q      <= armed_d;
      index_q      <= index_d;
      valid_q      <= valid_d;
      ramping_q    <= ramping_d;
      for (int unsigned k = 0; k < N2; k++) begin
        shadow_q[k] <= shadow_d[k];
        cur_q[k]    <= cur_d[k];
        tgt_q[k]    <= tgt_d[k];
      end
    end
  end

  // Pack current gains, entry 0 in the MSBs.
  always_comb begin
    volume = '0;
    for (int unsigned k = 0; k < N2; k++) begin
      volume[(N2 - 1 - k) * GAIN_W +: GAIN_W] = cur_q[k];
    end
  end

  assign volume_valid = valid_q;
  assign ramping      = ramping_q;

endmodule

// File: tb/tb_dsp_volume_matrix.sv
// Bench for dsp_volume_matrix: directed sequences plus random register traffic,
// checked cycle by cycle against a dB/linear reference model via a scoreboard.
module tb_dsp_volume_matrix;

  localparam int NUM_CH    = 2;
  localparam int GAIN_W    = 8;
  localparam int RAMP_STEP = 4;
  localparam int N2        = NUM_CH * NUM_CH;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [7:0]             dspa = '0;
  logic [7:0]             dspd = '0;
  logic                   dspd_strobe = 1'b0;
  logic                   sample_tick = 1'b0;
  logic [N2*GAIN_W-1:0]   volume;
  logic                   volume_valid;
  logic                   ramping;

  dsp_volume_matrix #(
    .NUM_CH   (NUM_CH),
    .GAIN_W   (GAIN_W),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dspa        (dspa),
    .dspd        (dspd),
    .dspd_strobe (dspd_strobe),
    .sample_tick (sample_tick),
    .volume      (volume),
    .volume_valid(volume_valid),
    .ramping     (ramping)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N2*GAIN_W-1:0] vol;
    logic                 valid;
    logic                 ramp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int            m_cur [N2];
  int            m_tgt [N2];
  int            m_mode;
  bit            m_armed;
  int            m_seq[$];
  bit            m_valid;
  bit            m_ramp;

  function automatic int gain_of(input int b);
    if (b >= 128) return 0;
    if (b >= 50) return 0;
    return $rtoi(144.0 * $pow(10.0, -b / 20.0) + 0.5);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N2; k++) begin
      m_cur[k] = ((k % (NUM_CH + 1)) == 0) ? 144 : 0;
      m_tgt[k] = m_cur[k];
    end
    m_mode  = 0;
    m_armed = 0;
    m_seq.delete();
    m_valid = 0;
    m_ramp  = 0;
  endtask

  task automatic model_edge(input bit rst_n, input int a, input int d, input bit s, input bit t);
    bit any_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    any_diff = 0;
    for (int k = 0; k < N2; k++) if (m_cur[k] != m_tgt[k]) any_diff = 1;
    for (int k = 0; k < N2; k++) begin
      if (RAMP_STEP == 0) m_cur[k] = m_tgt[k];
      else if (t) begin
        if (m_cur[k] < m_tgt[k])
          m_cur[k] = (m_cur[k] + RAMP_STEP > m_tgt[k]) ? m_tgt[k] : m_cur[k] + RAMP_STEP;
        else if (m_cur[k] > m_tgt[k])
          m_cur[k] = (m_cur[k] - RAMP_STEP < m_tgt[k]) ? m_tgt[k] : m_cur[k] - RAMP_STEP;
      end
    end
    if (s) begin
      if (a == 0) begin
        m_mode  = d;
        m_armed = 0;
        m_seq.delete();
      end else if (a == 1) begin
        if (m_mode == 'h80 && d == 'h93) begin
          m_armed = 1;
          m_seq.delete();
        end else begin
          m_armed = 0;
        end
      end else if (a == 7 && m_armed) begin
        m_seq.push_back(d);
        if (m_seq.size() == N2) begin
          for (int k = 0; k < N2; k++) m_tgt[k] = gain_of(m_seq[k]);
          m_valid = 1;
          m_seq.delete();
        end
      end
    end
    m_ramp = any_diff;
  endtask

  task automatic step(input bit rst_n, input logic [7:0] a, input logic [7:0] d,
                      input bit s, input bit t);
    exp_t e;
    reset       = rst_n;
    dspa        = a;
    dspd        = d;
    dspd_strobe = s;
    sample_tick = t;
    model_edge(rst_n, int'(a), int'(d), s, t);
    @(posedge clk);
    e.vol = '0;
    for (int k = 0; k < N2; k++) e.vol[(N2 - 1 - k) * GAIN_W +: GAIN_W] = GAIN_W'(m_cur[k]);
    e.valid = m_valid;
    e.ramp  = m_ramp;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic arm();
    wr(8'd0, 8'h80);
    wr(8'd1, 8'h93);
  endtask

  // Monitor: compare one expected entry per cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (volume !== e.vol) begin
          errors++;
          $display("FAIL volume at %0t: got %h required %h", $time, volume, e.vol);
        end
        checks++;
        if (volume_valid !== e.valid) begin
          errors++;
          $display("FAIL volume_valid at %0t: got %b required %b", $time, volume_valid, e.valid);
        end
        checks++;
        if (ramping !== e.ramp) begin
          errors++;
          $display("FAIL ramping at %0t: got %b required %b", $time, ramping, e.ramp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    model_reset();
    // Reset, then idle with no writes.
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(3);
    ticks(2);

    // Full commit: {0 dB, mute, mute, 6 dB}; entry 3 ramps 144 -> 72.
    arm();
    wr(8'd7, 8'h00);
    wr(8'd7, 8'h80);
    wr(8'd7, 8'h80);
    wr(8'd7, 8'h06);
    ticks(20);
    idle(2);

    // Partial sequence aborted by a mode write; later data writes ignored.
    arm();
    wr(8'd7, 8'd12);
    wr(8'd7, 8'd12);
    wr(8'd7, 8'd12);
    wr(8'd0, 8'h00);
    wr(8'd7, 8'd20);
    wr(8'd7, 8'd20);
    wr(8'd7, 8'd20);
    wr(8'd7, 8'd20);
    ticks(3);

    // Two back-to-back sets without re-arming.
    arm();
    wr(8'd7, 8'd1);
    wr(8'd7, 8'd12);
    wr(8'd7, 8'd20);
    wr(8'd7, 8'd40);
    wr(8'd7, 8'd6);
    wr(8'd7, 8'd0);
    wr(8'd7, 8'd12);
    wr(8'd7, 8'd1);
    ticks(40);

    // Attenuation sweep edge values.
    arm();
    wr(8'd7, 8'd49);
    wr(8'd7, 8'd50);
    wr(8'h07, 8'h7F);
    wr(8'h07, 8'h85);
    ticks(40);

    // Commit on a tick cycle while ramping, then reset mid-ramp.
    arm();
    wr(8'd7, 8'd0);
    wr(8'd7, 8'd0);
    wr(8'd7, 8'd0);
    ticks(2);
    step(1'b1, 8'd7, 8'd0, 1'b1, 1'b1);
    ticks(3);
    step(1'b0, 8'd7, 8'd3, 1'b1, 1'b1);
    idle(3);
    ticks(2);

    // Random register traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end else if (r < 10) begin
        wr(8'd0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80);
        wr(8'd1, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h93);
      end else if (r < 45) begin
        step(1'b1, 8'd7,
             ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 55)),
             1'b1, 1'($urandom));
      end else if (r < 55) begin
        step(1'b1, 8'($urandom_range(0, 9)), 8'($urandom), 1'b1, 1'($urandom));
      end else begin
        step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'($urandom));
      end
    end
    ticks(40);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_volume_matrix.md
Name: dsp_volume_matrix

Overview:
- Parametrised successor to the FMA DSP attenuation register block.
- Decodes the DSP register write stream (dspa/dspd/dspd_strobe) into an NUM_CH x NUM_CH source-to-destination attenuation matrix.
- Commits a complete matrix atomically and ramps each linear gain toward its target once per audio sample tick, so volume changes do not click.
- Sits between the MPEG FMA DSP register port and the audio mixer.

Parameters:
- NUM_CH, 2, number of audio channels; the matrix has NUM_CH*NUM_CH coefficients (N2).
- GAIN_W, 8, width of each linear gain output; must be >= 8; values are zero-extended.
- RAMP_STEP, 4, gain increment per sample_tick while ramping; 0 means the target is applied on the cycle after commit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- dspa  in  8  DSP register address
- dspd  in  8  DSP register write data
- dspd_strobe  in  1  one-cycle write qualifier for dspa/dspd
- sample_tick  in  1  one-cycle pulse per output audio sample
- volume  out  N2*GAIN_W  current linear gains, packed; entry k sits at bits [(N2-1-k)*GAIN_W +: GAIN_W], so entry 0 is in the MSBs
- volume_valid  out  1  at least one full matrix has been committed since reset
- ramping  out  1  some current gain differs from its target

Behaviour:
- One clock. Reset is synchronous, active-low, and sampled on clk only.
- Reset values:
  - mode = 0, target = 0, armed = 0, index = 0, volume_valid = 0, ramping = 0.
  - Current and target gains: diagonal entries (k % (NUM_CH+1) == 0) = 144, all others = 0.
  - Shadow registers = 0.
- Register decode, effective only on dspd_strobe:
  - dspa 0: mode <= dspd. Any write to mode also clears armed and index, aborting a partial sequence.
  - dspa 1: target <= dspd. The arm check uses the newly written value: if mode == 0x80 and dspd == 0x93, then armed <= 1 and index <= 0; otherwise armed <= 0.
  - dspa 7 with armed == 1:
    - shadow[index] <= dspd; index increments.
    - On the write with index == N2-1, commit all N2 entries (the shadow plus this byte) to the targets in the same cycle, set volume_valid <= 1, and wrap index to 0. armed stays 1, so another full set may follow.
  - dspa 7 with armed == 0: ignored.
  - All other addresses: ignored.
- A partial sequence never reaches the targets. It is discarded on re-arm or on a mode write.
- dB to linear conversion, applied at commit:
  - dspd[7] == 1 means mute: gain 0.
  - Otherwise g = round(144 * 10^(-dspd[6:0]/20)), from a constant 0..49 table; dB >= 50 gives 0.
  - Key values: 0->144, 1->128, 6->72, 12->36, 20->14, 40->1, 49->1, 50->0.
- Ramp, per entry, on each sample_tick:
  - cur < tgt: cur <= min(cur + RAMP_STEP, tgt).
  - cur > tgt: cur <= max(cur - RAMP_STEP, tgt).
  - Equal: hold.
  - Computed at GAIN_W+1 bits; no wrap.
- RAMP_STEP == 0: cur <= tgt on the cycle after commit, independent of sample_tick.
- Commit and sample_tick in the same cycle: that tick ramps toward the old targets; new targets apply from the next tick.
- ramping is registered: it is 1 on the cycle after any cur != tgt, and drops to 0 on the cycle after the last entry converges.
- volume is driven directly from the current gain registers; there is no combinational path from dspd to volume.
- Reset mid-sequence or mid-ramp returns everything to the reset values on that edge.

Test Plan:
- Release reset with no writes -> volume = {144,0,0,144} (NUM_CH=2), volume_valid=0, ramping=0.
- Write 0:0x80, 1:0x93, then 7: 0x00, 0x80, 0x80, 0x06 -> commit on the 4th write; targets {144,0,0,72}; volume_valid=1; with RAMP_STEP=4, entry 3 reaches 72 after 18 ticks and ramping drops on the following cycle.
- Arm, then write only 3 bytes at dspa 7, then write 0:0x00 -> targets unchanged, index=0; later writes at dspa 7 ignored.
- Arm, write 4 bytes, then 4 more without re-arming -> two commits; the second set becomes the targets.
- Attenuation sweep with dB = 49, 50, 0x7F, 0x85 -> gains 1, 0, 0, 0.
- Commit coinciding with sample_tick, and assert reset mid-ramp -> the tick steps toward the old targets; reset restores the reset values on the next edge.
